// File: rtl/instr_issue_pkg.sv
// Shared types for the instruction issue block: operation encoding,
// the issue FSM states and the default sizing parameters.
package instr_issue_pkg;

    localparam int DEF_DEPTH   = 8;
    localparam int DEF_TIMEOUT = 64;
    localparam int IDX_W       = 4;

    typedef enum logic [2:0] {
        NO_OP        = 3'd0,
        OP_CT_CT_ADD = 3'd1,
        OP_CT_CT_MUL = 3'd2,
        OP_CT_PT_ADD = 3'd3,
        OP_CT_PT_MUL = 3'd4
    } op_e;

    typedef struct packed {
        op_e              mode;
        logic [IDX_W-1:0] idx1_a;
        logic [IDX_W-1:0] idx1_b;
        logic [IDX_W-1:0] idx2_a;
        logic [IDX_W-1:0] idx2_b;
        logic [IDX_W-1:0] out_a;
        logic [IDX_W-1:0] out_b;
    } operation;

    localparam operation OP_NONE = '{NO_OP, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        HUNG  = 2'd3
    } issue_state_e;

endpackage

// File: rtl/instr_issue_if.sv
// Host/CPU-facing signal bundle of the instruction issue block.
interface instr_issue_if;
    import instr_issue_pkg::*;

    logic        push_valid;
    operation    push_op;
    logic        push_ready;
    operation    op_out;
    logic        cpu_done;
    logic        busy;
    logic        queue_empty;
    logic [15:0] retired_count;
    logic        hang;

    modport master (
        output push_valid, push_op, cpu_done,
        input  push_ready, op_out, busy, queue_empty, retired_count, hang
    );

    modport slave (
        input  push_valid, push_op, cpu_done,
        output push_ready, op_out, busy, queue_empty, retired_count, hang
    );
endinterface

// File: rtl/instr_issue_op_fifo.sv
// Synchronous FIFO of operations; pushes while full and pops while empty
// are ignored.
module op_fifo
    import instr_issue_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic     clk,
    input  logic     reset,
    input  logic     push,
    input  operation wr_op,
    input  logic     pop,
    output operation rd_op,
    output logic     full,
    output logic     empty
);
    localparam int PW = $clog2(DEPTH);

    operation        mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [PW:0]     count;
    logic            do_push;
    logic            do_pop;

    assign full    = (count == (PW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_op   = mem[rd_ptr];

    // Storage write; contents need no reset since count gates visibility
    always_ff @(posedge clk) begin
        if (reset && do_push) begin
            mem[wr_ptr] <= wr_op;
        end
    end

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/instr_issue.sv
// Instruction issue sequencer: queues host operations and hands them to the
// CPU one at a time, waiting for completion with a hang watchdog.
module instr_issue
    import instr_issue_pkg::*;
#(
    parameter int DEPTH   = DEF_DEPTH,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input logic          clk,
    input logic          reset,
    instr_issue_if.slave bus
);
    localparam int CNT_W = $clog2(TIMEOUT) + 1;
    localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(TIMEOUT - 1);

    issue_state_e     state, next_state;
    operation         op_q;
    operation         head_op;
    logic [CNT_W-1:0] wait_cnt;
    logic [15:0]      retired;
    logic             hang_q;
    logic             fifo_full;
    logic             fifo_empty;
    logic             pop;
    logic             done_in_wait;

    op_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (bus.push_valid),
        .wr_op (bus.push_op),
        .pop   (pop),
        .rd_op (head_op),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign done_in_wait      = (state == WAIT) && bus.cpu_done;
    assign bus.push_ready    = !fifo_full;
    assign bus.busy          = (state != IDLE);
    assign bus.queue_empty   = fifo_empty;
    assign bus.retired_count = retired;
    assign bus.hang          = hang_q;
    // op_out depends only on registered state and op_q
    assign bus.op_out        = (state == ISSUE || state == WAIT) ? op_q : OP_NONE;

    // Next-state and head-pop decision
    always_comb begin
        next_state = state;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    next_state = ISSUE;
                    pop        = 1'b1;
                end
            end
            ISSUE: next_state = WAIT;
            WAIT: begin
                if (bus.cpu_done) begin
                    if (!fifo_empty) begin
                        next_state = ISSUE;
                        pop        = 1'b1;
                    end else begin
                        next_state = IDLE;
                    end
                end else if (wait_cnt == LAST_WAIT) begin
                    next_state = HUNG;
                end
            end
            HUNG:    next_state = HUNG;
            default: next_state = IDLE;
        endcase
    end

    // State, in-flight operation, watchdog and completion counters
    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            op_q     <= OP_NONE;
            wait_cnt <= '0;
            retired  <= '0;
            hang_q   <= 1'b0;
        end else begin
            state <= next_state;
            if (pop) op_q <= head_op;
            wait_cnt <= (state == WAIT && !bus.cpu_done) ? wait_cnt + 1'b1 : '0;
            if (done_in_wait) retired <= retired + 1'b1;
            if (state == WAIT && next_state == HUNG) hang_q <= 1'b1;
        end
    end
endmodule

// File: tb/tb_instr_issue.sv
// Directed self-checking bench for instr_issue.
module tb_instr_issue;
    import instr_issue_pkg::*;

    localparam int DEPTH_T = 8;
    localparam int TO      = 16;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;
    operation ops [10];
    operation op_m;

    always #5 clk = ~clk;

    instr_issue_if bus ();

    instr_issue #(.DEPTH(DEPTH_T), .TIMEOUT(TO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic operation mk(input op_e m, input logic [3:0] v);
        return '{m, v, v + 4'd1, v + 4'd2, v + 4'd3, v + 4'd4, v + 4'd5};
    endfunction

    initial begin
        bus.push_valid = 1'b0;
        bus.push_op    = OP_NONE;
        bus.cpu_done   = 1'b0;
        for (int i = 0; i < 9; i++) ops[i] = mk((i % 2) ? OP_CT_PT_MUL : OP_CT_CT_ADD, 4'(i));
        ops[9] = mk(OP_CT_PT_ADD, 4'd9);
        op_m   = mk(OP_CT_PT_MUL, 4'd7);

        // reset state
        step(); step(); step();
        check("rst_push_ready", 32'(bus.push_ready), 32'd1);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_queue_empty", 32'(bus.queue_empty), 32'd1);
        check("rst_op_out", 32'(bus.op_out), 32'(OP_NONE));
        check("rst_retired", 32'(bus.retired_count), 32'd0);
        check("rst_hang", 32'(bus.hang), 32'd0);

        // idle after release
        reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            check("idle_mode", 32'(bus.op_out.mode), 32'(NO_OP));
            check("idle_push_ready", 32'(bus.push_ready), 32'd1);
            check("idle_busy", 32'(bus.busy), 32'd0);
        end

        // single op, done on the third cycle it is driven
        bus.push_valid = 1'b1;
        bus.push_op    = mk(OP_CT_CT_ADD, 4'd0);
        step();
        bus.push_valid = 1'b0;
        check("one_queued", 32'(bus.queue_empty), 32'd0);
        check("one_pre_op", 32'(bus.op_out), 32'(OP_NONE));
        step();
        check("one_issue_op", 32'(bus.op_out), 32'(mk(OP_CT_CT_ADD, 4'd0)));
        check("one_issue_busy", 32'(bus.busy), 32'd1);
        check("one_popped", 32'(bus.queue_empty), 32'd1);
        step();
        check("one_wait1_op", 32'(bus.op_out), 32'(mk(OP_CT_CT_ADD, 4'd0)));
        step();
        check("one_wait2_op", 32'(bus.op_out), 32'(mk(OP_CT_CT_ADD, 4'd0)));
        bus.cpu_done = 1'b1;
        step();
        bus.cpu_done = 1'b0;
        check("one_retired", 32'(bus.retired_count), 32'd1);
        check("one_idle", 32'(bus.busy), 32'd0);
        check("one_idle_op", 32'(bus.op_out), 32'(OP_NONE));

        // cpu_done while idle is ignored
        bus.cpu_done = 1'b1;
        step();
        bus.cpu_done = 1'b0;
        check("idle_done_ignored", 32'(bus.retired_count), 32'd1);

        // fill: one in flight plus DEPTH queued, then an extra push
        for (int i = 0; i < 9; i++) begin
            bus.push_valid = 1'b1;
            bus.push_op    = ops[i];
            step();
        end
        check("full_push_ready", 32'(bus.push_ready), 32'd0);
        bus.push_op = ops[9];
        step();
        bus.push_valid = 1'b0;
        check("full_still_full", 32'(bus.push_ready), 32'd0);

        // drain in order with back-to-back issue
        for (int k = 0; k < 9; k++) begin
            check("order_op", 32'(bus.op_out), 32'(ops[k]));
            bus.cpu_done = 1'b1;
            step();
            bus.cpu_done = 1'b0;
            if (k == 0) check("pop_frees_slot", 32'(bus.push_ready), 32'd1);
            if (k < 8) begin
                check("b2b_op", 32'(bus.op_out), 32'(ops[k+1]));
                step();
            end
        end
        check("drain_retired", 32'(bus.retired_count), 32'd10);
        check("drain_idle", 32'(bus.busy), 32'd0);
        check("drain_empty", 32'(bus.queue_empty), 32'd1);

        // done on the last allowed WAIT cycle completes
        bus.push_valid = 1'b1;
        bus.push_op    = op_m;
        step();
        bus.push_valid = 1'b0;
        step();
        step();
        for (int i = 0; i < TO - 1; i++) step();
        check("edge_op", 32'(bus.op_out), 32'(op_m));
        bus.cpu_done = 1'b1;
        step();
        bus.cpu_done = 1'b0;
        check("edge_no_hang", 32'(bus.hang), 32'd0);
        check("edge_retired", 32'(bus.retired_count), 32'd11);
        check("edge_idle", 32'(bus.busy), 32'd0);

        // no done: hang exactly TO cycles after entering WAIT
        bus.push_valid = 1'b1;
        bus.push_op    = op_m;
        step();
        bus.push_valid = 1'b0;
        step();
        step();
        for (int i = 0; i < TO - 1; i++) begin
            step();
            check("pre_hang", 32'(bus.hang), 32'd0);
        end
        check("pre_hang_op", 32'(bus.op_out), 32'(op_m));
        step();
        check("hang_set", 32'(bus.hang), 32'd1);
        check("hang_op", 32'(bus.op_out), 32'(OP_NONE));
        check("hang_busy", 32'(bus.busy), 32'd1);

        // HUNG accepts pushes and ignores cpu_done
        bus.push_valid = 1'b1;
        bus.push_op    = ops[1];
        step();
        bus.push_valid = 1'b0;
        check("hung_push", 32'(bus.queue_empty), 32'd0);
        bus.cpu_done = 1'b1;
        step();
        bus.cpu_done = 1'b0;
        check("hung_retired", 32'(bus.retired_count), 32'd11);
        check("hung_sticky", 32'(bus.hang), 32'd1);
        check("hung_op", 32'(bus.op_out), 32'(OP_NONE));

        // clear, then reset mid-WAIT with three queued
        reset = 1'b0;
        step();
        reset = 1'b1;
        check("clr_hang", 32'(bus.hang), 32'd0);
        for (int i = 0; i < 4; i++) begin
            bus.push_valid = 1'b1;
            bus.push_op    = ops[i];
            step();
        end
        bus.push_valid = 1'b0;
        check("mid_busy", 32'(bus.busy), 32'd1);
        check("mid_queued", 32'(bus.queue_empty), 32'd0);
        check("mid_op", 32'(bus.op_out), 32'(ops[0]));
        reset = 1'b0;
        bus.push_valid = 1'b1;
        bus.push_op    = ops[5];
        step();
        check("mr_empty", 32'(bus.queue_empty), 32'd1);
        check("mr_op", 32'(bus.op_out), 32'(OP_NONE));
        check("mr_retired", 32'(bus.retired_count), 32'd0);
        check("mr_busy", 32'(bus.busy), 32'd0);
        check("mr_push_ready", 32'(bus.push_ready), 32'd1);
        reset = 1'b1;
        bus.push_valid = 1'b0;
        step();
        check("post_rst_empty", 32'(bus.queue_empty), 32'd1);
        check("post_rst_busy", 32'(bus.busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
